uartmm_fifo: RTL
================

Name: uartmm_fifo

Overview:
- Parametrised successor to the single-byte memory-mapped UART. It contains its own 8N1 transmitter and receiver, a runtime-programmable baud divisor, and RX/TX FIFOs of parametrised depth.
- Sticky error flags and a level interrupt output are added.
- It sits on CPU data port B beside socram. It answers only its own 4-word address window, returning read data on data_b with strobe_b.

Parameters:
BASE, 65537, word address of register 0; window is BASE..BASE+3
DEPTH_LOG2, 4, log2 of entries per FIFO (RX and TX each hold 2**DEPTH_LOG2 bytes)
DEFAULT_DIV, 433, reset value of DIVISOR (clocks per bit minus 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
RX  in  1  serial input, asynchronous to clk
TX  out  1  serial output, idle high
irq  out  1  level interrupt
data_b  out  32  registered read data
strobe_b  out  1  high when data_b is valid for this block
addr_b  in  32  word address
data_b_in  in  32  write data
data_b_we  in  32  write enable; any nonzero value = write

Behaviour:
- Reset (rst low, asynchronous) clears the following: both FIFOs empty, TX=1, irq=0, data_b=0, strobe_b=0, stickies=0, IRQ_EN=0, DIVISOR=DEFAULT_DIV, RX/TX FSMs IDLE.
- Register map (offset from BASE):
  - +0 STATUS (R): bit0 rx_avail, bit1 tx_space, bit2 tx_idle (FIFO empty and FSM IDLE), bit3 overrun, bit4 framing_err, bits[31:5]=0.
  - +0 STATUS (W): writing 1 to bit3/bit4 clears that sticky.
  - +1 DATA (R): head of the RX FIFO in [7:0], zero-extended; pops the FIFO. Returns 0 if the FIFO is empty, with no pop.
  - +1 DATA (W): pushes data_b_in[7:0] to the TX FIFO. The write is dropped if the FIFO is full.
  - +2 DIVISOR (R/W): 16 bits. A write takes effect at the next bit boundary, never mid-bit.
  - +3 IRQ_EN (R/W): bit0 enables rx_avail, bit1 enables tx_idle, bit2 enables the sticky errors.
- Bus timing:
  - strobe_b and data_b are registered. They are valid exactly 1 cycle after addr_b falls in the window.
  - strobe_b=0 and data_b=0 for any out-of-window address.
- Side-effect qualification:
  - A DATA pop or push fires only on the first cycle of a run of identical (addr_b, we) values.
  - A single access held for N cycles therefore pops or pushes once.
  - A back-to-back access to a different offset rearms the qualification.
- RX path:
  - Two-flop synchroniser on RX.
  - IDLE -> START on a falling edge.
  - Sample at DIVISOR/2 (integer). If the line is high there, it is a false start: return to IDLE.
  - DATA state: 8 samples LSB-first, one every DIVISOR+1 clocks.
  - STOP state: sample the stop bit. If it is 0, set framing_err and discard the byte. Otherwise push the byte.
  - If the FIFO is full at push, drop the new byte and set overrun. The FIFO contents are unchanged.
- TX path:
  - IDLE: when the FIFO is non-empty, pop and load the byte.
  - START: drive 0 for one bit. DATA: 8 bits LSB-first. STOP: drive 1 for one bit.
  - STOP -> IDLE; the next byte can start on the following clock.
  - Each bit lasts DIVISOR+1 clocks.
- FIFOs:
  - Circular with DEPTH_LOG2+1-bit pointers. Full = MSBs differ and LSBs equal.
  - Simultaneous push and pop on a full FIFO: both succeed.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push succeeds.
- irq is registered: irq = |(IRQ_EN & {any_sticky, tx_idle, rx_avail}).
- Reset mid-frame aborts immediately: TX returns high in the same clock (asynchronous), and the partial RX byte is discarded.

Test Plan:
- Reset with DIVISOR at default -> read BASE+2 -> data_b=433 with strobe_b=1 one cycle later. Read address 0x20000 -> strobe_b=0, data_b=0.
- Write DIVISOR=3, then write 0x55 and 0xA3 to DATA -> TX shows two back-to-back 10-bit frames, 4 clocks per bit. STATUS bit2 returns to 1 after 80 clocks.
- Drive RX with 0x3C at DIVISOR=3 -> STATUS=0x7. DATA read returns 0x3C, then STATUS=0x6. A second DATA read returns 0, and a DATA read with the address held 5 cycles pops only once.
- Send 2**DEPTH_LOG2+1 bytes with no reads -> overrun set. Reads return the first 16 bytes in order; the 17th is lost. Writing 0x8 to STATUS clears overrun.
- Send a frame with stop bit 0 -> framing_err set, no byte pushed. With IRQ_EN=0x4, irq rises one cycle after the flag; writing 0x10 to STATUS lowers irq.
- Assert rst low mid-TX-frame, asynchronously to clk -> TX=1 before the next edge. After release, the FIFOs are empty and DIVISOR=433.

Source files
------------

// File: rtl/uartmm_fifo.sv
// Memory-mapped 8N1 UART with RX/TX FIFOs, programmable divisor, sticky errors and irq.
// Answers a 4-word window on CPU data port B; read data and strobe are registered.
module uartmm_fifo #(
  parameter logic [31:0] BASE        = 32'd65537,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic        irq,
  output logic [31:0] data_b,
  output logic        strobe_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] data_b_in,
  input  logic [31:0] data_b_we
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam logic [15:0] DivRst = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Bus decode
  logic [31:0] off;
  logic        in_win, bus_wr, acc_first, sel_data, bus_pop, bus_push, wr_status;
  logic [31:0] acc_addr_q;
  logic        acc_we_q, acc_vld_q;

  assign off       = addr_b - BASE;
  assign in_win    = (off < 32'd4);
  assign bus_wr    = |data_b_we;
  // Side effects fire only on the first cycle of a run of identical (addr, we).
  assign acc_first = !acc_vld_q || (addr_b != acc_addr_q) || (bus_wr != acc_we_q);
  assign sel_data  = in_win && (off[1:0] == 2'd1);
  assign wr_status = in_win && bus_wr && (off[1:0] == 2'd0);

  // Registers
  logic [15:0] div_q;
  logic [2:0]  irq_en_q;
  logic        ov_q, fr_q, ov_d, fr_d, ov_set, fr_set;
  logic        irq_q, tx_q;
  logic [31:0] data_q, rdata;
  logic        strobe_q;

  // FIFO state
  logic [DEPTH_LOG2:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [7:0]          tx_mem [Depth];
  logic [7:0]          rx_mem [Depth];
  logic                tx_empty, tx_full, rx_empty, rx_full;
  logic                tx_pop, tx_push_ok, rx_push_req, rx_push_ok;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[DEPTH_LOG2] != tx_rp_q[DEPTH_LOG2]) &&
                    (tx_wp_q[DEPTH_LOG2-1:0] == tx_rp_q[DEPTH_LOG2-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[DEPTH_LOG2] != rx_rp_q[DEPTH_LOG2]) &&
                    (rx_wp_q[DEPTH_LOG2-1:0] == rx_rp_q[DEPTH_LOG2-1:0]);

  assign bus_pop    = sel_data && !bus_wr && acc_first && !rx_empty;
  assign bus_push   = sel_data && bus_wr && acc_first;
  // A full FIFO still accepts a push when a pop happens in the same cycle.
  assign tx_push_ok = bus_push && (!tx_full || tx_pop);
  assign rx_push_ok = rx_push_req && (!rx_full || bus_pop);
  assign ov_set     = rx_push_req && !rx_push_ok;

  // TX FSM state
  uart_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_d, tx_idle;

  assign tx_idle = tx_empty && (tx_st_q == StIdle);

  // RX FSM state
  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;

  logic unused_wdata;
  assign unused_wdata = ^data_b_in[31:16];

  // TX next state: each bit is held for div_q+1 clocks, reloaded at every bit boundary
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      StIdle: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem[tx_rp_q[DEPTH_LOG2-1:0]];
          tx_cnt_d = div_q;
          tx_st_d  = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q != 16'd0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
          tx_cnt_d = div_q;
          tx_idx_d = 3'd0;
          tx_st_d  = StData;
        end
      end
      StData: begin
        if (tx_cnt_q != 16'd0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
          tx_cnt_d = div_q;
          if (tx_idx_q == 3'd7) begin
            tx_st_d = StStop;
          end else begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
        else                   tx_st_d  = StIdle;
      end
      default: tx_st_d = StIdle;
    endcase
    // Line level follows the next state so TX is a clean register output.
    unique case (tx_st_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX next state: sample mid-bit, first sample div_q/2 after the falling edge
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_idx_d    = rx_idx_q;
    rx_push_req = 1'b0;
    fr_set      = 1'b0;
    unique case (rx_st_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d = div_q >> 1;
          rx_st_d  = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_sync_q) begin
          rx_st_d = StIdle;  // false start
        end else begin
          rx_cnt_d = div_q;
          rx_idx_d = 3'd0;
          rx_st_d  = StData;
        end
      end
      StData: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_idx_q == 3'd7) rx_st_d  = StStop;
          else                  rx_idx_d = rx_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_st_d = StIdle;
          if (rx_sync_q) rx_push_req = 1'b1;
          else           fr_set      = 1'b1;
        end
      end
      default: rx_st_d = StIdle;
    endcase
  end

  // Register read mux and sticky next state; a set in the same cycle beats a clear
  always_comb begin
    rdata = 32'd0;
    unique case (off[1:0])
      2'd0:    rdata = {27'd0, fr_q, ov_q, tx_idle, !tx_full, !rx_empty};
      2'd1:    rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp_q[DEPTH_LOG2-1:0]]};
      2'd2:    rdata = {16'd0, div_q};
      default: rdata = {29'd0, irq_en_q};
    endcase
    ov_d = ov_set | (ov_q & ~(wr_status & data_b_in[3]));
    fr_d = fr_set | (fr_q & ~(wr_status & data_b_in[4]));
  end

  // FIFO storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wp_q[DEPTH_LOG2-1:0]] <= data_b_in[7:0];
    if (rx_push_ok) rx_mem[rx_wp_q[DEPTH_LOG2-1:0]] <= rx_sh_q;
  end

  // All control state, bus registers and FSM registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_addr_q <= 32'd0;
      acc_we_q   <= 1'b0;
      acc_vld_q  <= 1'b0;
      div_q      <= DivRst;
      irq_en_q   <= 3'd0;
      ov_q       <= 1'b0;
      fr_q       <= 1'b0;
      irq_q      <= 1'b0;
      data_q     <= 32'd0;
      strobe_q   <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_st_q    <= StIdle;
      tx_cnt_q   <= 16'd0;
      tx_sh_q    <= 8'd0;
      tx_idx_q   <= 3'd0;
      tx_q       <= 1'b1;
      rx_st_q    <= StIdle;
      rx_cnt_q   <= 16'd0;
      rx_sh_q    <= 8'd0;
      rx_idx_q   <= 3'd0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      acc_addr_q <= addr_b;
      acc_we_q   <= bus_wr;
      acc_vld_q  <= 1'b1;
      if (in_win && bus_wr && off[1:0] == 2'd2) div_q    <= data_b_in[15:0];
      if (in_win && bus_wr && off[1:0] == 2'd3) irq_en_q <= data_b_in[2:0];
      ov_q       <= ov_d;
      fr_q       <= fr_d;
      irq_q      <= |(irq_en_q & {ov_q | fr_q, tx_idle, !rx_empty});
      data_q     <= in_win ? rdata : 32'd0;
      strobe_q   <= in_win;
      if (tx_push_ok) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)     tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push_ok) rx_wp_q <= rx_wp_q + 1'b1;
      if (bus_pop)    rx_rp_q <= rx_rp_q + 1'b1;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_idx_q   <= tx_idx_d;
      tx_q       <= tx_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_idx_q   <= rx_idx_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign TX       = tx_q;
  assign irq      = irq_q;
  assign data_b   = data_q;
  assign strobe_b = strobe_q;

endmodule
